// File: rtl/rect_plotter.sv
// Rectangle plotter for the VGA adapter write port: draws a BOX_W x BOX_H box
// clipped to the screen, or sweeps the whole screen in BLACK_COLOUR.
module rect_plotter #(
    parameter int X_SCREEN_PIXELS = 160,
    parameter int Y_SCREEN_PIXELS = 120,
    parameter int X_W             = 8,
    parameter int Y_W             = 7,
    parameter int C_W             = 3,
    parameter int BOX_W           = 4,
    parameter int BOX_H           = 4,
    parameter int BLACK_COLOUR    = 0
) (
    input  logic           iClock,
    input  logic           iResetn,
    input  logic           iLoadX,
    input  logic           iPlotBox,
    input  logic           iBlack,
    input  logic [X_W-1:0] iXY_Coord,
    input  logic [C_W-1:0] iColour,
    output logic [X_W-1:0] oX,
    output logic [Y_W-1:0] oY,
    output logic [C_W-1:0] oColour,
    output logic           oPlot,
    output logic           oBusy,
    output logic           oDone
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [X_W-1:0] DRAW_X_LAST  = X_W'(BOX_W - 1);
    localparam logic [Y_W-1:0] DRAW_Y_LAST  = Y_W'(BOX_H - 1);
    localparam logic [X_W-1:0] CLEAR_X_LAST = X_W'(X_SCREEN_PIXELS - 1);
    localparam logic [Y_W-1:0] CLEAR_Y_LAST = Y_W'(Y_SCREEN_PIXELS - 1);
    localparam logic [X_W:0]   X_LIMIT      = (X_W+1)'(X_SCREEN_PIXELS);
    localparam logic [Y_W:0]   Y_LIMIT      = (Y_W+1)'(Y_SCREEN_PIXELS);
    localparam logic [C_W-1:0] BLACK_C      = C_W'(BLACK_COLOUR);

    function automatic logic in_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
        return (px < X_LIMIT) && (py < Y_LIMIT);
    endfunction

    logic [1:0]     state;
    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;
    logic [C_W-1:0] colour_reg;
    logic           plot_q;
    logic           black_q;
    logic [X_W-1:0] cnt_x;
    logic [Y_W-1:0] cnt_y;

    logic           plot_rise;
    logic           black_rise;
    logic           clearing;
    logic           sweep;
    logic           x_last;
    logic           y_last;
    logic           pix_last;
    logic [X_W:0]   px;
    logic [Y_W:0]   py;

    logic [X_W-1:0] px_p0;
    logic [Y_W-1:0] py_p0;
    logic [C_W-1:0] colour_p0;
    logic           vis_p0;
    logic           vld_p0;
    logic           last_p0;
    logic           last_p1;

    assign plot_rise  = iPlotBox & ~plot_q;
    assign black_rise = iBlack & ~black_q;
    assign clearing   = (state == S_CLEAR);
    assign sweep      = (state == S_DRAW) || clearing;
    assign x_last     = clearing ? (cnt_x == CLEAR_X_LAST) : (cnt_x == DRAW_X_LAST);
    assign y_last     = clearing ? (cnt_y == CLEAR_Y_LAST) : (cnt_y == DRAW_Y_LAST);
    assign pix_last   = x_last && y_last;

    // Pixel coordinates one bit wider than the screen so clipping sees overflow.
    assign px = clearing ? {1'b0, cnt_x} : ({1'b0, x_reg} + {1'b0, cnt_x});
    assign py = clearing ? {1'b0, cnt_y} : ({1'b0, y_reg} + {1'b0, cnt_y});

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state      <= S_IDLE;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            plot_q     <= 1'b0;
            black_q    <= 1'b0;
            cnt_x      <= '0;
            cnt_y      <= '0;
        end else begin
            plot_q  <= iPlotBox;
            black_q <= iBlack;
            case (state)
                S_IDLE: begin
                    if (iLoadX)
                        x_reg <= iXY_Coord;
                    cnt_x <= '0;
                    cnt_y <= '0;
                    if (black_rise) begin
                        state <= S_CLEAR;
                    end else if (plot_rise) begin
                        state      <= S_DRAW;
                        y_reg      <= iXY_Coord[Y_W-1:0];
                        colour_reg <= iColour;
                    end
                end
                S_DRAW, S_CLEAR: begin
                    if (pix_last) begin
                        state <= S_DONE;
                        cnt_x <= '0;
                        cnt_y <= '0;
                    end else if (x_last) begin
                        cnt_x <= '0;
                        cnt_y <= cnt_y + 1'b1;
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end
                default: begin
                    // Held until the final pixel has drained to the outputs.
                    if (last_p1)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- stage p0: pixel data captured from the counters ----
    always_ff @(posedge iClock) begin
        px_p0     <= px[X_W-1:0];
        py_p0     <= py[Y_W-1:0];
        colour_p0 <= clearing ? BLACK_C : colour_reg;
        vis_p0    <= in_screen(px, py);
    end

    // ---- stage p1: registered VGA write port ----
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            last_p1 <= 1'b0;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
        end else begin
            vld_p0  <= sweep;
            last_p0 <= sweep && pix_last;
            last_p1 <= last_p0;
            oPlot   <= vld_p0 && vis_p0;
            if (vld_p0 && vis_p0) begin
                oX      <= px_p0;
                oY      <= py_p0;
                oColour <= colour_p0;
            end
            oBusy <= (state != S_IDLE);
            oDone <= last_p1;
        end
    end

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: table of rectangle draws plus hand-written
// clear, collision, mid-draw, reset-abort and small-box sequences.
module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rstb_n;
    logic       load_x;
    logic       plot_box;
    logic       black;
    logic [7:0] xy;
    logic [2:0] colour;

    logic [7:0] ax, bx;
    logic [6:0] ay, by;
    logic [2:0] acol, bcol;
    logic       aplot, abusy, adone;
    logic       bplot, bbusy, bdone;

    always #5 clk = ~clk;

    rect_plotter dut (
        .iClock(clk), .iResetn(rst_n), .iLoadX(load_x), .iPlotBox(plot_box),
        .iBlack(black), .iXY_Coord(xy), .iColour(colour),
        .oX(ax), .oY(ay), .oColour(acol), .oPlot(aplot), .oBusy(abusy), .oDone(adone)
    );

    rect_plotter #(.BOX_W(3), .BOX_H(2)) dut_b (
        .iClock(clk), .iResetn(rstb_n), .iLoadX(load_x), .iPlotBox(plot_box),
        .iBlack(black), .iXY_Coord(xy), .iColour(colour),
        .oX(bx), .oY(by), .oColour(bcol), .oPlot(bplot), .oBusy(bbusy), .oDone(bdone)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] hold_x;
    logic [6:0] hold_y;
    logic [2:0] hold_c;

    // mode: 0 = reuse previous X, 1 = load X first, 2 = load X in the plot cycle
    typedef struct {
        int mode;
        int x;
        int y;
        int c;
        int n_vis;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rect(input string tag, input int mode, input int x, input int y,
                            input int c, input int n_vis);
        int  nplot;
        int  ex, ey;
        logic ep;
        nplot = 0;
        if (mode == 1) begin
            xy = 8'(x);
            load_x = 1'b1;
            tick();
            load_x = 1'b0;
        end
        if (mode == 2) begin
            xy = 8'(x);
            load_x = 1'b1;
        end else begin
            xy = 8'(y);
        end
        colour   = 3'(c);
        plot_box = 1'b1;
        tick();
        plot_box = 1'b0;
        load_x   = 1'b0;
        xy       = 8'h55;
        check({tag, " busy@T"}, 32'(abusy), 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            ep = 1'b0;
            if (k >= 2 && k <= 17) begin
                ex = x + (k - 2) % 4;
                ey = y + (k - 2) / 4;
                ep = (ex < 160) && (ey < 120);
            end
            if (ep) begin
                hold_x = 8'(ex);
                hold_y = 7'(ey);
                hold_c = 3'(c);
            end
            if (aplot) nplot++;
            check($sformatf("%s k=%0d plot", tag, k), 32'(aplot), 32'(ep));
            check($sformatf("%s k=%0d busy", tag, k), 32'(abusy), 32'(k <= 18));
            check($sformatf("%s k=%0d done", tag, k), 32'(adone), 32'(k == 18));
            check($sformatf("%s k=%0d x", tag, k), 32'(ax), 32'(hold_x));
            check($sformatf("%s k=%0d y", tag, k), 32'(ay), 32'(hold_y));
            check($sformatf("%s k=%0d colour", tag, k), 32'(acol), 32'(hold_c));
        end
        check({tag, " pixel count"}, nplot, n_vis);
    endtask

    initial begin
        int count, first_k, done_k, done_n, stray, colerr, orderr;
        int fx, fy, lx, ly, ex, ey;
        logic busy_at_done;

        vecs[0] = '{1, 10,  20,  5, 16};
        vecs[1] = '{0, 10,  40,  6, 16};
        vecs[2] = '{1, 158, 118, 2, 4};
        vecs[3] = '{1, 0,   0,   7, 16};
        vecs[4] = '{1, 159, 50,  1, 4};
        vecs[5] = '{1, 100, 119, 3, 4};
        vecs[6] = '{2, 30,  30,  4, 16};
        vecs[7] = '{1, 200, 10,  1, 0};

        rst_n = 1'b0; rstb_n = 1'b0;
        load_x = 1'b0; plot_box = 1'b0; black = 1'b0;
        xy = '0; colour = '0;
        hold_x = '0; hold_y = '0; hold_c = '0;

        #12;
        check("reset oX", 32'(ax), 0);
        check("reset oY", 32'(ay), 0);
        check("reset oColour", 32'(acol), 0);
        check("reset oPlot", 32'(aplot), 0);
        check("reset oBusy", 32'(abusy), 0);
        check("reset oDone", 32'(adone), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_rect($sformatf("vec%0d", i), vecs[i].mode, vecs[i].x, vecs[i].y,
                     vecs[i].c, vecs[i].n_vis);

        // iPlotBox rising mid-draw is neither honoured nor queued
        xy = 8'd10; load_x = 1'b1; tick(); load_x = 1'b0;
        xy = 8'd20; colour = 3'd5; plot_box = 1'b1; tick(); plot_box = 1'b0;
        count = 0; done_n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) plot_box = 1'b1;
            tick();
            if (aplot) count++;
            if (adone) done_n++;
            if (k == 30) plot_box = 1'b0;
        end
        check("middraw pixel count", count, 16);
        check("middraw done pulses", done_n, 1);
        check("middraw idle after", 32'(abusy), 0);
        hold_x = 8'd13; hold_y = 7'd23; hold_c = 3'd5;

        // Simultaneous plot and clear: full clear only
        xy = 8'd60; colour = 3'd5; plot_box = 1'b1; black = 1'b1;
        tick();
        plot_box = 1'b0; black = 1'b0;
        count = 0; first_k = -1; done_k = -1; done_n = 0; stray = 0;
        colerr = 0; orderr = 0; fx = -1; fy = -1; lx = -1; ly = -1;
        ex = 0; ey = 0; busy_at_done = 1'b0;
        for (int k = 1; k <= 19215; k++) begin
            tick();
            if (aplot) begin
                if (first_k < 0) begin
                    first_k = k; fx = ax; fy = ay;
                end
                lx = ax; ly = ay;
                count++;
                if (acol != 3'd0) colerr++;
                if (ax != 8'(ex) || ay != 7'(ey)) orderr++;
                if (ex == 159) begin ex = 0; ey++; end else ex++;
                if (k < 2 || k > 19201) stray++;
            end else if (k >= 2 && k <= 19201) begin
                stray++;
            end
            if (adone) begin
                done_n++; done_k = k; busy_at_done = abusy;
            end
        end
        check("clear pixel count", count, 19200);
        check("clear first cycle", first_k, 2);
        check("clear first x", fx, 0);
        check("clear first y", fy, 0);
        check("clear last x", lx, 159);
        check("clear last y", ly, 119);
        check("clear colour errors", colerr, 0);
        check("clear raster order errors", orderr, 0);
        check("clear plot gaps/stray", stray, 0);
        check("clear done cycle", done_k, 19202);
        check("clear done pulses", done_n, 1);
        check("clear busy at done", 32'(busy_at_done), 1);
        check("clear idle after", 32'(abusy), 0);

        // Asynchronous reset mid-clear, then a clean restart
        black = 1'b1; tick(); black = 1'b0;
        repeat (100) tick();
        check("abort plotting before reset", 32'(aplot), 1);
        rst_n = 1'b0;
        #1;
        check("abort oPlot", 32'(aplot), 0);
        check("abort oBusy", 32'(abusy), 0);
        check("abort oX", 32'(ax), 0);
        check("abort oY", 32'(ay), 0);
        #3;
        rst_n = 1'b1;
        tick();
        hold_x = '0; hold_y = '0; hold_c = '0;
        run_rect("after_reset", 1, 5, 6, 3, 16);

        // 3x2 box build
        #4;
        rstb_n = 1'b1;
        tick();
        xy = 8'd0; load_x = 1'b1; tick(); load_x = 1'b0;
        xy = 8'd0; colour = 3'd6; plot_box = 1'b1; tick(); plot_box = 1'b0;
        check("box3x2 busy@T", 32'(bbusy), 0);
        count = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bplot) count++;
            check($sformatf("box3x2 k=%0d plot", k), 32'(bplot), 32'(k >= 2 && k <= 7));
            check($sformatf("box3x2 k=%0d done", k), 32'(bdone), 32'(k == 8));
            check($sformatf("box3x2 k=%0d busy", k), 32'(bbusy), 32'(k <= 8));
            if (k >= 2 && k <= 7) begin
                check($sformatf("box3x2 k=%0d x", k), 32'(bx), 32'((k - 2) % 3));
                check($sformatf("box3x2 k=%0d y", k), 32'(by), 32'((k - 2) / 3));
                check($sformatf("box3x2 k=%0d colour", k), 32'(bcol), 6);
            end
        end
        check("box3x2 pixel count", count, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
